// File: rtl/commonlib_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : commonlib_arb_pkg                                                 |
// | Brief  : Shared types and index helpers for the round-robin mux arbiter.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package commonlib_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // An index field needs at least one bit, even for a single requester.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/commonlib_muxn_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : commonlib_muxn_rr_arbiter_if                                      |
// | Brief  : Requester/consumer handshake bundle of the round-robin arbiter.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface commonlib_muxn_rr_arbiter_if
  import commonlib_arb_pkg::*;
#(
  parameter int N     = 5,
  parameter int width = 32
) ();
  localparam int SELW = sel_width(N);

  logic [width-1:0] in_data [N-1:0];
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic [width-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic [SELW-1:0]  out_sel;
  logic             busy;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_sel, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_sel, busy
  );
endinterface
`default_nettype wire

// File: rtl/commonlib_muxn.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : commonlib_muxn                                                    |
// | Brief  : N-way word multiplexer; out-of-range select yields zero.          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module commonlib_muxn
  import commonlib_arb_pkg::*;
#(
  parameter  int N     = 5,
  parameter  int width = 32,
  localparam int SELW  = sel_width(N)
) (
  input  logic [width-1:0] in_data [N-1:0],
  input  logic [SELW-1:0]  in_sel,
  output logic [width-1:0] out_data
);
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (in_sel == SELW'(i)) out_data = in_data[i];
    end
  end
endmodule
`default_nettype wire

// File: rtl/commonlib_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : commonlib_rr_pick                                                 |
// | Brief  : Rotating-priority picker: first request at or after ptr, wrapping.|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module commonlib_rr_pick
  import commonlib_arb_pkg::*;
#(
  parameter  int N    = 5,
  localparam int SELW = sel_width(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [SELW-1:0] ptr_i,
  output logic            any_o,
  output logic [SELW-1:0] idx_o
);
  logic [2*N-1:0] dreq_w;
  logic [2*N-1:0] mask_w;
  logic [2*N-1:0] cand_w;
  logic           found_w;

  // The upper copy supplies the wrapped-around requests below ptr.
  assign dreq_w = {req_i, req_i};
  assign cand_w = dreq_w & mask_w;
  assign any_o  = |req_i;

  always_comb begin
    mask_w = '0;
    for (int j = 0; j < 2 * N; j++) begin
      mask_w[j] = (j >= int'(ptr_i));
    end
  end

  always_comb begin
    idx_o   = '0;
    found_w = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!found_w && cand_w[j]) begin
        found_w = 1'b1;
        idx_o   = SELW'((j >= N) ? (j - N) : j);
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/commonlib_muxn_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : commonlib_muxn_rr_arbiter                                         |
// | Brief  : Round-robin arbiter with optional packet lock and output register.|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module commonlib_muxn_rr_arbiter
  import commonlib_arb_pkg::*;
#(
  parameter int N     = 5,
  parameter int width = 32,
  parameter bit LOCK  = 1'b1
) (
  input logic CLK,
  input logic RESET,
  commonlib_muxn_rr_arbiter_if.slave bus
);
  localparam int SELW = sel_width(N);

  arb_state_e       state_q, state_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [SELW-1:0]  lock_idx_q, lock_idx_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;
  logic [width-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic             load_w;
  logic             pick_any_w;
  logic [SELW-1:0]  pick_idx_w;
  logic [SELW-1:0]  grant_w;
  logic             sel_valid_w;
  logic             sel_last_w;
  logic             xfer_w;
  logic [width-1:0] mux_data_w;
  logic [width-1:0] in_data_w [N-1:0];
  logic [N-1:0]     in_ready_w;
  logic             busy_w;

  assign load_w    = !out_valid_q || bus.out_ready;
  assign in_data_w = bus.in_data;

  commonlib_rr_pick #(.N(N)) u_pick (
    .req_i (bus.in_valid),
    .ptr_i (ptr_q),
    .any_o (pick_any_w),
    .idx_o (pick_idx_w)
  );

  assign grant_w = (state_q == LOCKED) ? lock_idx_q : pick_idx_w;

  commonlib_muxn #(.N(N), .width(width)) u_mux (
    .in_data  (in_data_w),
    .in_sel   (grant_w),
    .out_data (mux_data_w)
  );

  always_comb begin
    sel_valid_w = 1'b0;
    sel_last_w  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_w == SELW'(i)) begin
        sel_valid_w = bus.in_valid[i];
        sel_last_w  = bus.in_last[i];
      end
    end
  end

  // In IDLE an empty request vector picks index 0 whose valid is low, so no transfer.
  assign xfer_w = load_w && sel_valid_w && (pick_any_w || (state_q == LOCKED));

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    if (LOCK && xfer_w) begin
      case (state_q)
        IDLE: begin
          if (!sel_last_w) begin
            state_d    = LOCKED;
            lock_idx_d = grant_w;
          end
        end
        LOCKED: begin
          if (sel_last_w) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    busy_w     = (state_q == LOCKED);
    in_ready_w = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_w == SELW'(i)) begin
        in_ready_w[i] = load_w && ((state_q == LOCKED) || bus.in_valid[i]);
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_w) begin
      out_valid_d = xfer_w;
      if (xfer_w) begin
        out_data_d = mux_data_w;
        out_last_d = sel_last_w;
        out_sel_d  = grant_w;
        ptr_d      = SELW'(rr_next(int'(grant_w), N));
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
      lock_idx_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.busy      = busy_w;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_sel   = out_sel_q;
endmodule
`default_nettype wire

// File: tb/tb_commonlib_muxn_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_commonlib_muxn_rr_arbiter                                      |
// | Brief  : Directed bench with a cycle model for three arbiter configs.      |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_commonlib_muxn_rr_arbiter;
  typedef logic [31:0] arr5_t [4:0];

  typedef struct {
    bit          ov;
    logic [31:0] od;
    bit          ol;
    int          os;
    bit          locked;
    int          owner;
    int          ptr;
  } mdl_t;

  logic clk = 1'b0;
  logic rst;
  int   nchk = 0;
  int   nerr = 0;
  int   qA[$];
  int   qB[$];
  int   qBd[$];
  mdl_t mA, mB, mC;
  arr5_t dC;

  always #5 clk = ~clk;

  commonlib_muxn_rr_arbiter_if #(.N(5), .width(32)) ifA ();
  commonlib_muxn_rr_arbiter_if #(.N(5), .width(32)) ifB ();
  commonlib_muxn_rr_arbiter_if #(.N(1), .width(32)) ifC ();

  commonlib_muxn_rr_arbiter #(.N(5), .width(32), .LOCK(1'b1)) u_a (.CLK(clk), .RESET(rst), .bus(ifA));
  commonlib_muxn_rr_arbiter #(.N(5), .width(32), .LOCK(1'b0)) u_b (.CLK(clk), .RESET(rst), .bus(ifB));
  commonlib_muxn_rr_arbiter #(.N(1), .width(32), .LOCK(1'b1)) u_c (.CLK(clk), .RESET(rst), .bus(ifC));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_seq(input string nm, input int act[$], input int exp[$]);
    chk({nm, "_len"}, 32'(act.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      if (k < act.size()) chk($sformatf("%s[%0d]", nm, k), 32'(act[k]), 32'(exp[k]));
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.ov = 1'b0; m.od = '0; m.ol = 1'b0; m.os = 0;
    m.locked = 1'b0; m.owner = 0; m.ptr = 0;
    return m;
  endfunction

  // Checks one cycle of outputs, then advances the model across the next edge.
  task automatic model_step(input string nm, input int n, input bit lk, inout mdl_t m,
                            input logic rst_i, input logic [4:0] v, input logic [4:0] l,
                            input arr5_t d, input logic ordy,
                            input logic ov_a, input logic [31:0] od_a, input logic ol_a,
                            input logic [31:0] os_a, input logic busy_a, input logic [4:0] rdy_a);
    bit         load;
    int         g;
    logic [4:0] er;
    chk({nm, ".out_valid"}, 32'(ov_a), 32'(m.ov));
    if (m.ov) begin
      chk({nm, ".out_data"}, od_a, m.od);
      chk({nm, ".out_last"}, 32'(ol_a), 32'(m.ol));
      chk({nm, ".out_sel"}, os_a, 32'(m.os));
    end
    chk({nm, ".busy"}, 32'(busy_a), 32'(m.locked));
    load = !m.ov || ordy;
    g = -1;
    if (m.locked) g = m.owner;
    else begin
      for (int k = 0; k < n; k++) begin
        int idx;
        idx = (m.ptr + k) % n;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    er = '0;
    if (load && g >= 0 && (m.locked || v[g])) er[g] = 1'b1;
    chk({nm, ".in_ready"}, 32'(rdy_a), 32'(er));
    if (rst_i) m = mdl_reset();
    else if (load) begin
      if (g >= 0 && v[g]) begin
        m.ov  = 1'b1;
        m.od  = d[g];
        m.ol  = l[g];
        m.os  = g;
        m.ptr = (g + 1) % n;
        if (lk) begin
          if (!m.locked && !l[g]) begin
            m.locked = 1'b1;
            m.owner  = g;
          end else if (m.locked && l[g]) begin
            m.locked = 1'b0;
          end
        end
      end else begin
        m.ov = 1'b0;
      end
    end
  endtask

  initial begin
    mA = mdl_reset(); mB = mdl_reset(); mC = mdl_reset();
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step("A", 5, 1'b1, mA, rst, ifA.in_valid, ifA.in_last, ifA.in_data, ifA.out_ready,
                 ifA.out_valid, ifA.out_data, ifA.out_last, 32'(ifA.out_sel), ifA.busy, ifA.in_ready);
      model_step("B", 5, 1'b0, mB, rst, ifB.in_valid, ifB.in_last, ifB.in_data, ifB.out_ready,
                 ifB.out_valid, ifB.out_data, ifB.out_last, 32'(ifB.out_sel), ifB.busy, ifB.in_ready);
      dC = '{default: '0};
      dC[0] = ifC.in_data[0];
      model_step("C", 1, 1'b1, mC, rst, {4'b0, ifC.in_valid}, {4'b0, ifC.in_last}, dC, ifC.out_ready,
                 ifC.out_valid, ifC.out_data, ifC.out_last, 32'(ifC.out_sel), ifC.busy, {4'b0, ifC.in_ready});
      if (ifA.out_valid === 1'b1) qA.push_back(int'(ifA.out_sel));
      if (ifB.out_valid === 1'b1) begin
        qB.push_back(int'(ifB.out_sel));
        qBd.push_back(int'(ifB.out_data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setA(input int i, input logic v, input logic l, input logic [31:0] d);
    ifA.in_valid[i] = v;
    ifA.in_last[i]  = l;
    ifA.in_data[i]  = d;
  endtask

  task automatic setC(input logic v, input logic l, input logic [31:0] d);
    ifC.in_valid[0] = v;
    ifC.in_last[0]  = l;
    ifC.in_data[0]  = d;
  endtask

  initial begin
    rst = 1'b1;
    ifA.in_valid = '0; ifA.in_last = '0; ifA.out_ready = 1'b1;
    ifB.in_valid = '0; ifB.in_last = '0; ifB.out_ready = 1'b1;
    ifC.in_valid = '0; ifC.in_last = '0; ifC.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ifA.in_data[i] = '0;
      ifB.in_data[i] = 32'hA0 + 32'(i);
    end
    ifC.in_data[0] = '0;
    ifB.in_valid = 5'h1F;
    ifB.in_last  = 5'h1F;

    // Reset state
    tick();
    @(negedge clk);
    chk("rst_out_valid", 32'(ifA.out_valid), 32'd0);
    chk("rst_out_data", ifA.out_data, 32'd0);
    chk("rst_out_sel", 32'(ifA.out_sel), 32'd0);
    chk("rst_busy", 32'(ifA.busy), 32'd0);
    tick();
    rst = 1'b0;

    // LOCK=0 round robin, all valid
    qB.delete(); qBd.delete();
    @(negedge clk);
    chk("B_no_valid_before_first_edge", 32'(ifB.out_valid), 32'd0);
    repeat (6) tick();
    ifB.in_valid = '0;
    tick();
    chk_seq("B_sel", qB, '{0, 1, 2, 3, 4, 0});
    chk_seq("B_data", qBd, '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA0});

    // Backpressure on A
    ifA.out_ready = 1'b0;
    setA(2, 1'b1, 1'b1, 32'h1234);
    tick();
    ifA.in_data[2] = 32'h5678;
    repeat (3) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(ifA.out_valid), 32'd1);
      chk("bp_hold_data", ifA.out_data, 32'h1234);
      chk("bp_hold_sel", 32'(ifA.out_sel), 32'd2);
      chk("bp_hold_ready", 32'(ifA.in_ready), 32'd0);
      tick();
    end
    ifA.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(ifA.in_ready), 32'b00100);
    tick();
    setA(2, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("bp_second_word", ifA.out_data, 32'h5678);
    tick();

    // Packet lock: requester 1 holds the mux against requester 3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    qA.delete();
    setA(1, 1'b1, 1'b0, 32'h11);
    setA(3, 1'b1, 1'b1, 32'h33);
    tick();
    setA(1, 1'b0, 1'b0, 32'h11);
    @(negedge clk);
    chk("lock_busy_after_w1", 32'(ifA.busy), 32'd1);
    chk("lock_bubble_ready", 32'(ifA.in_ready), 32'b00010);
    tick();
    setA(1, 1'b1, 1'b0, 32'h12);
    tick();
    setA(1, 1'b1, 1'b1, 32'h13);
    tick();
    setA(1, 1'b0, 1'b0, 32'h0);
    setA(0, 1'b1, 1'b1, 32'h10);
    @(negedge clk);
    chk("lock_busy_after_w3", 32'(ifA.busy), 32'd0);
    tick();
    setA(3, 1'b0, 1'b0, 32'h0);
    tick();
    setA(0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_seq("lock_sel", qA, '{1, 1, 1, 3, 0});

    // Wrap with N=5: ptr moved to 4, then only 4 and 0 compete
    qA.delete();
    setA(3, 1'b1, 1'b1, 32'h33);
    tick();
    setA(3, 1'b0, 1'b0, 32'h0);
    setA(4, 1'b1, 1'b1, 32'h44);
    setA(0, 1'b1, 1'b1, 32'h40);
    repeat (4) tick();
    setA(4, 1'b0, 1'b0, 32'h0);
    setA(0, 1'b0, 1'b0, 32'h0);
    tick();
    chk_seq("wrap_sel", qA, '{3, 4, 0, 4, 0});

    // Reset while locked with a word held
    setA(2, 1'b1, 1'b0, 32'h22);
    tick();
    setA(2, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    ifA.out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(ifA.busy), 32'd1);
    chk("pre_rst_valid", 32'(ifA.out_valid), 32'd1);
    tick();
    rst = 1'b0;
    ifA.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) setA(i, 1'b1, 1'b1, 32'h50 + 32'(i));
    qA.delete();
    @(negedge clk);
    chk("post_rst_valid", 32'(ifA.out_valid), 32'd0);
    chk("post_rst_busy", 32'(ifA.busy), 32'd0);
    chk("post_rst_sel", 32'(ifA.out_sel), 32'd0);
    tick();
    ifA.in_valid = '0;
    tick();
    chk_seq("post_rst_grant", qA, '{0});

    // N=1
    setC(1'b1, 1'b1, 32'hC1);
    tick();
    setC(1'b0, 1'b1, 32'hC2);
    @(negedge clk);
    chk("n1_valid_1", 32'(ifC.out_valid), 32'd1);
    chk("n1_data_1", ifC.out_data, 32'hC1);
    chk("n1_sel_known", 32'($isunknown(ifC.out_sel)), 32'd0);
    chk("n1_sel_1", 32'(ifC.out_sel), 32'd0);
    tick();
    setC(1'b1, 1'b1, 32'hC3);
    @(negedge clk);
    chk("n1_valid_0", 32'(ifC.out_valid), 32'd0);
    tick();
    setC(1'b1, 1'b0, 32'hC4);
    @(negedge clk);
    chk("n1_valid_2", 32'(ifC.out_valid), 32'd1);
    chk("n1_data_2", ifC.out_data, 32'hC3);
    tick();
    setC(1'b1, 1'b1, 32'hC5);
    @(negedge clk);
    chk("n1_busy", 32'(ifC.busy), 32'd1);
    tick();
    setC(1'b0, 1'b0, 32'h0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/commonlib_muxn_rr_arbiter.md
Name: commonlib_muxn_rr_arbiter

Overview:
Round-robin arbiter that shares one commonlib_muxn__N{N}__width{width} datapath between N valid/ready requesters, and registers the selected word onto one output channel.
- Generates the mux select (grant index) itself.
- Supports optional packet locking: a granted requester keeps the mux until it transfers a word with in_last.
- Sits between several producer streams and a single shared consumer, e.g. in front of a memory write port or an output FIFO.

Parameters:
N, 5, number of requesters (1..64)
width, 32, data word width in bits
LOCK, 1, 1 = hold grant until in_last transfer; 0 = re-arbitrate after every word
SELW, max(1, clog2(N)), select/grant index width (derived, not overridden)

Ports:
CLK  input  1  clock, all state updates on rising edge
RESET  input  1  synchronous reset, active-high
in_data  input  N x width  requester data words, unpacked array [N-1:0]
in_valid  input  N  per-requester valid
in_last  input  N  per-requester end-of-packet flag, sampled with in_data
in_ready  output  N  per-requester ready (combinational; at most one bit high)
out_data  output  width  registered selected word
out_valid  output  1  registered output valid
out_last  output  1  registered in_last of the held word
out_ready  input  1  consumer ready
out_sel  output  SELW  index of requester whose word is held in out_data
busy  output  1  1 while state = LOCKED

Behaviour:
- Reset, synchronous and active-high: out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, state=IDLE, busy=0. RESET overrides every other input in the same cycle. Reset mid-packet drops the lock; any held word is discarded (no handshake).
- load = !out_valid || out_ready. Output register is single-entry; full throughput when out_ready stays high.
- Pick:
  - IDLE: grant g = first index i with in_valid[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - LOCKED: g = lock_idx, regardless of other valids.
- in_ready[g] = load && in_valid[g] (IDLE) or load (LOCKED). All other bits are 0. in_ready never depends on out_valid of the same cycle beyond load.
- Transfer on requester g (in_valid[g] && in_ready[g]):
  - out_data<=in_data[g], out_last<=in_last[g], out_sel<=g, out_valid<=1.
  - Latency exactly 1 cycle from transfer to out_valid.
- If load=1 and no transfer occurs, out_valid<=0 on that edge. out_data, out_last and out_sel hold their values.
- ptr update on each transfer: ptr<=g+1, wrapping to 0 when g=N-1. This applies in LOCKED state too, so the pointer is past the locked requester when the packet ends.
- State machine (LOCK=1 only; with LOCK=0 state stays IDLE):
  - IDLE->LOCKED: transfer with in_last[g]=0; lock_idx<=g.
  - LOCKED->IDLE: transfer from lock_idx with in_last=1.
  - LOCKED->LOCKED: otherwise. lock_idx's in_valid deasserting does not release the lock; other requesters stall.
  - IDLE->IDLE: transfer with in_last=1, or no transfer.
- Output hold: while out_valid=1 && out_ready=0, out_data/out_last/out_sel are stable and all in_ready=0.
- N=1: SELW=1, out_sel always 0, grant trivially index 0. ptr wraps to 0 every transfer.
- N not a power of two: ptr and g never exceed N-1, and scan indices wrap modulo N, not modulo 2^SELW.
- Data path: g drives in_sel of the muxn instance combinationally. Its output feeds the out_data register. No arithmetic on data.

Decomposition:
- Package commonlib_arb_pkg:
  - clog2 function and SELW derivation;
  - state enum {IDLE, LOCKED};
  - rr_next(ptr, N) wrap helper.
- Sub-module commonlib_rr_pick: combinational rotating priority picker.
  - Inputs: req[N], ptr[SELW].
  - Outputs: any, idx[SELW].
  - Implemented as double-width mask and priority encode.
- Existing commonlib_muxn instantiated for data selection. Top level holds the FSM, ptr, lock_idx and output register.

Test Plan:
- N=5, LOCK=0; all in_valid=1, in_last=1, out_ready=1, in_data[i]=32'hA0+i. Expected: out_sel sequence 0,1,2,3,4,0; out_data A0..A4,A0; one word per cycle, first out_valid 1 cycle after reset release.
- Backpressure: single requester 2 valid with D=32'h1234, out_ready=0 for 3 cycles. Expected: out_valid=1, out_data=1234, out_sel=2 stable; in_ready=0 throughout; transfer completes on the first cycle with out_ready=1.
- LOCK=1; requester 1 sends 3 words (last on the 3rd) while requester 3 stays valid. Expected: out_sel=1,1,1 then 3; busy=1 after word 1 and 0 after word 3; ptr=2 at release.
- Wrap and non-power-of-two: only requesters 4 and 0 valid, ptr=4. Expected: grants 4,0,4,0; out_sel never reaches 5..7.
- RESET asserted while LOCKED with out_valid=1. Expected: next cycle out_valid=0, busy=0, out_sel=0, ptr=0; with all valid, the first grant after reset is 0.
- N=1: in_valid toggled 1,0,1. Expected: out_valid follows one cycle later, out_sel=0 always, and no X on in_sel.
